// File: rtl/cache_axi_bridge.sv
// Bridges icache/dcache read and dcache write requests onto a single AXI4 master port.
// Latency: request accepted combinationally in idle; AR/AW issued the next cycle; read beats forwarded combinationally.
// Backpressure: one read and one write outstanding; *_rd_rdy/d_wr_rdy low while the matching path is busy.
module cache_axi_bridge #(
    parameter int         LINE_WORDS = 4,
    parameter logic [3:0] IID        = 4'd0,
    parameter logic [3:0] DID        = 4'd1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_rd_req,
    input  logic [2:0]   i_rd_type,
    input  logic [31:0]  i_rd_addr,
    output logic         i_rd_rdy,
    output logic         i_ret_valid,
    output logic         i_ret_last,
    output logic [31:0]  i_ret_data,
    input  logic         d_rd_req,
    input  logic [2:0]   d_rd_type,
    input  logic [31:0]  d_rd_addr,
    output logic         d_rd_rdy,
    output logic         d_ret_valid,
    output logic         d_ret_last,
    output logic [31:0]  d_ret_data,
    input  logic         d_wr_req,
    input  logic [2:0]   d_wr_type,
    input  logic [31:0]  d_wr_addr,
    input  logic [3:0]   d_wr_wstrb,
    input  logic [127:0] d_wr_data,
    output logic         d_wr_rdy,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);
    localparam int         BW       = $clog2(LINE_WORDS);
    localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);
    localparam logic [2:0] T_LINE   = 3'b100;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_W, W_B} w_state_t;

    r_state_t    r_state, r_next;
    w_state_t    w_state, w_next;
    logic        r_is_d;
    logic [7:0]  beat;
    logic [31:0] line_q [LINE_WORDS];
    logic        d_hazard, d_acc, i_acc, w_acc;

    // Routing is by the latched requester, so rid and the response codes are not needed.
    logic unused_ok;
    assign unused_ok = ^{rid, rresp, bresp};

    // A dcache read may not overtake a pending write to the same 16-byte line.
    assign d_hazard = (w_state != W_IDLE) && (d_rd_addr[31:4] == awaddr[31:4]);
    assign d_acc    = resetn && (r_state == R_IDLE) && d_rd_req && !d_hazard;
    assign i_acc    = resetn && (r_state == R_IDLE) && i_rd_req && !d_acc;
    assign w_acc    = (w_state == W_IDLE) && d_wr_req;
    assign d_rd_rdy = d_acc;
    assign i_rd_rdy = i_acc;
    assign d_wr_rdy = resetn && (w_state == W_IDLE);

    // Read state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= R_IDLE;
        else         r_state <= r_next;
    end

    // Read next-state and read-channel outputs.
    always_comb begin
        r_next      = r_state;
        arvalid     = 1'b0;
        rready      = 1'b0;
        i_ret_valid = 1'b0;
        d_ret_valid = 1'b0;
        case (r_state)
            R_IDLE: if (d_acc || i_acc) r_next = R_AR;
            R_AR: begin
                arvalid = 1'b1;
                if (arready) r_next = R_R;
            end
            R_R: begin
                rready      = 1'b1;
                d_ret_valid = rvalid && r_is_d;
                i_ret_valid = rvalid && !r_is_d;
                if (rvalid && rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign i_ret_data = i_ret_valid ? rdata : 32'd0;
    assign i_ret_last = i_ret_valid && rlast;
    assign d_ret_data = d_ret_valid ? rdata : 32'd0;
    assign d_ret_last = d_ret_valid && rlast;

    // Capture the accepted read request; fields stay frozen until the next accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arid <= 4'd0; araddr <= 32'd0; arlen <= 8'd0;
            arsize <= 3'd0; arburst <= 2'd0; r_is_d <= 1'b0;
        end else if (d_acc) begin
            arid    <= DID;
            araddr  <= d_rd_addr;
            arlen   <= (d_rd_type == T_LINE) ? LINE_LEN : 8'd0;
            arsize  <= (d_rd_type == T_LINE) ? 3'b010 : {1'b0, d_rd_type[1:0]};
            arburst <= 2'b01;
            r_is_d  <= 1'b1;
        end else if (i_acc) begin
            arid    <= IID;
            araddr  <= i_rd_addr;
            arlen   <= (i_rd_type == T_LINE) ? LINE_LEN : 8'd0;
            arsize  <= (i_rd_type == T_LINE) ? 3'b010 : {1'b0, i_rd_type[1:0]};
            arburst <= 2'b01;
            r_is_d  <= 1'b0;
        end
    end

    // Write state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) w_state <= W_IDLE;
        else         w_state <= w_next;
    end

    // Write next-state and write-channel handshake outputs.
    always_comb begin
        w_next  = w_state;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (w_state)
            W_IDLE: if (d_wr_req) w_next = W_AW;
            W_AW: begin
                awvalid = 1'b1;
                if (awready) w_next = W_W;
            end
            W_W: begin
                wvalid = 1'b1;
                if (wready && (beat == awlen)) w_next = W_B;
            end
            W_B: begin
                bready = 1'b1;
                if (bvalid) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign wdata = line_q[beat[BW-1:0]];
    assign wlast = wvalid && (beat == awlen);

    // Capture the whole write request; a word write lives in word 0 of the line buffer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            awid <= 4'd0; awaddr <= 32'd0; awlen <= 8'd0;
            awsize <= 3'd0; awburst <= 2'd0; wstrb <= 4'd0;
            for (int k = 0; k < LINE_WORDS; k++) line_q[k] <= 32'd0;
        end else if (w_acc) begin
            awid    <= DID;
            awaddr  <= d_wr_addr;
            awlen   <= (d_wr_type == T_LINE) ? LINE_LEN : 8'd0;
            awsize  <= 3'b010;
            awburst <= 2'b01;
            wstrb   <= (d_wr_type == T_LINE) ? 4'hf : d_wr_wstrb;
            for (int k = 0; k < LINE_WORDS; k++) line_q[k] <= d_wr_data[k*32 +: 32];
        end
    end

    // Write beat counter: advances on each accepted W beat, clears after the last.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                beat <= 8'd0;
        else if (wvalid && wready)  beat <= (beat == awlen) ? 8'd0 : beat + 8'd1;
    end
endmodule
